// File: rtl/eth_pkg.sv
// Shared types for the ingress packet buffer.
package eth_pkg;

  localparam int ETH_DW = 32;

  typedef struct packed {
    logic              sop;
    logic              eop;
    logic [ETH_DW-1:0] data;
  } eth_word_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_RECV,
    W_DROP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_SEND
  } rd_state_t;

endpackage

// File: rtl/eth_dp_ram.sv
// Simple dual-port packet word store: one write port, one combinational read port.
module eth_dp_ram
  import eth_pkg::*;
#(
  parameter int DEPTH = 64,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  eth_word_t     i_wdata,
  input  logic [AW-1:0] i_raddr,
  output eth_word_t     o_rdata
);

  eth_word_t r_mem [DEPTH];

  // Write port; contents need no reset since pointers define what is valid.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/eth_ingress_buf.sv
// Store-and-forward ingress buffer: keeps only complete packets and releases
// them whole, honouring the switch stall only at packet boundaries.
module eth_ingress_buf
  import eth_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic [ETH_DW-1:0]       inData,
  input  logic                    inSop,
  input  logic                    inEop,
  output logic [ETH_DW-1:0]       outData,
  output logic                    outSop,
  output logic                    outEop,
  input  logic                    outStall,
  output logic [$clog2(DEPTH):0]  bufLevel,
  output logic [15:0]             dropCount
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  wr_state_t         r_wstate, w_wstateNxt;
  rd_state_t         r_rstate, w_rstateNxt;

  logic [PW-1:0]     r_wrPtr, r_commitPtr, r_rdPtr, r_pktCount;
  logic [PW-1:0]     w_wrPtrNxt, w_commitPtrNxt, w_base;
  logic              w_we, w_commit, w_rd, w_pktDec, w_canStart;
  logic [1:0]        w_dropInc;
  logic [16:0]       w_dropSum;
  logic [15:0]       r_dropCount;
  logic [ETH_DW-1:0] r_outData;
  logic              r_outSop, r_outEop;
  eth_word_t         w_wword, w_rword;

  eth_dp_ram #(.DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_base[AW-1:0]),
    .i_wdata (w_wword),
    .i_raddr (r_rdPtr[AW-1:0]),
    .o_rdata (w_rword)
  );

  // Write side: a sop always restarts at commitPtr, which both discards an
  // unfinished packet and makes overflow rollback a single pointer copy.
  always_comb begin
    w_wstateNxt    = r_wstate;
    w_wrPtrNxt     = r_wrPtr;
    w_commitPtrNxt = r_commitPtr;
    w_we           = 1'b0;
    w_commit       = 1'b0;
    w_dropInc      = '0;
    w_base         = inSop ? r_commitPtr : r_wrPtr;
    w_wword        = '{sop: inSop, eop: inEop, data: inData};
    if (inSop && (r_wstate == W_RECV)) begin
      w_dropInc = 2'd1;
    end
    if (inSop || (r_wstate == W_RECV)) begin
      if ((w_base - r_rdPtr) == PW'(DEPTH)) begin
        w_dropInc   = w_dropInc + 2'd1;
        w_wrPtrNxt  = r_commitPtr;
        w_wstateNxt = inEop ? W_IDLE : W_DROP;
      end else begin
        w_we       = 1'b1;
        w_wrPtrNxt = w_base + PW'(1);
        if (inEop) begin
          w_commit       = 1'b1;
          w_commitPtrNxt = w_base + PW'(1);
          w_wstateNxt    = W_IDLE;
        end else begin
          w_wstateNxt = W_RECV;
        end
      end
    end else if ((r_wstate == W_DROP) && inEop) begin
      w_wstateNxt = W_IDLE;
    end
  end

  // Read side: a new packet starts only when one is committed and no stall;
  // once started, words stream out every cycle until the eop word.
  always_comb begin
    w_rstateNxt = r_rstate;
    w_rd        = 1'b0;
    w_canStart  = (r_pktCount != '0) && !outStall;
    case (r_rstate)
      R_IDLE: begin
        if (w_canStart) begin
          w_rd        = 1'b1;
          w_rstateNxt = R_SEND;
        end
      end
      R_SEND: begin
        if (!r_outEop || w_canStart) begin
          w_rd = 1'b1;
        end else begin
          w_rstateNxt = R_IDLE;
        end
      end
      default: w_rstateNxt = R_IDLE;
    endcase
    w_pktDec = w_rd && w_rword.eop;
  end

  assign w_dropSum = {1'b0, r_dropCount} + 17'(w_dropInc);

  // Write-side state, pointers and saturating drop counter.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_wstate    <= W_IDLE;
      r_wrPtr     <= '0;
      r_commitPtr <= '0;
      r_dropCount <= '0;
    end else begin
      r_wstate    <= w_wstateNxt;
      r_wrPtr     <= w_wrPtrNxt;
      r_commitPtr <= w_commitPtrNxt;
      r_dropCount <= w_dropSum[16] ? 16'hFFFF : w_dropSum[15:0];
    end
  end

  // Read-side state, read pointer and committed-packet count.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_rstate   <= R_IDLE;
      r_rdPtr    <= '0;
      r_pktCount <= '0;
    end else begin
      r_rstate   <= w_rstateNxt;
      r_rdPtr    <= w_rd ? r_rdPtr + PW'(1) : r_rdPtr;
      r_pktCount <= r_pktCount + PW'(w_commit) - PW'(w_pktDec);
    end
  end

  // Registered output word; zero whenever nothing is being sent.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_outData <= '0;
      r_outSop  <= 1'b0;
      r_outEop  <= 1'b0;
    end else if (w_rd) begin
      r_outData <= w_rword.data;
      r_outSop  <= w_rword.sop;
      r_outEop  <= w_rword.eop;
    end else begin
      r_outData <= '0;
      r_outSop  <= 1'b0;
      r_outEop  <= 1'b0;
    end
  end

  assign outData   = r_outData;
  assign outSop    = r_outSop;
  assign outEop    = r_outEop;
  assign bufLevel  = r_wrPtr - r_rdPtr;
  assign dropCount = r_dropCount;

endmodule

// File: tb/tb_eth_ingress_buf.sv
// Scoreboard bench for eth_ingress_buf with DEPTH=16 and directed packets.
module tb_eth_ingress_buf;
  import eth_pkg::*;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        resetN;
  logic [31:0] inData;
  logic        inSop, inEop, outStall;
  logic [31:0] outData;
  logic        outSop, outEop;
  logic [4:0]  bufLevel;
  logic [15:0] dropCount;

  int        total = 0;
  int        bad   = 0;
  eth_word_t exp_q[$];
  bit        mon_ignore = 1'b0;
  bit        in_pkt = 1'b0;

  eth_ingress_buf #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .resetN    (resetN),
    .inData    (inData),
    .inSop     (inSop),
    .inEop     (inEop),
    .outData   (outData),
    .outSop    (outSop),
    .outEop    (outEop),
    .outStall  (outStall),
    .bufLevel  (bufLevel),
    .dropCount (dropCount)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: every output word is popped against the scoreboard.
  always begin
    eth_word_t e;
    @(posedge clk);
    #1;
    if (!resetN) begin
      in_pkt = 1'b0;
    end else if (!mon_ignore) begin
      if (outSop || in_pkt) begin
        if (exp_q.size() == 0) begin
          check("mon_unexpected", 64'({outSop, outEop, outData}), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("mon_word", 64'({outSop, outEop, outData}), 64'({e.sop, e.eop, e.data}));
        end
        in_pkt = !outEop;
      end else begin
        check("mon_idle_zero", 64'({outEop, outData}), 64'd0);
      end
    end
  end

  task automatic drive(input logic s, input logic e, input logic [31:0] d);
    @(negedge clk);
    inSop  = s;
    inEop  = e;
    inData = d;
  endtask

  task automatic idle_in();
    @(negedge clk);
    inSop  = 1'b0;
    inEop  = 1'b0;
    inData = '0;
  endtask

  task automatic send(input int n, input logic [31:0] base, input bit expect_out);
    for (int i = 0; i < n; i++) begin
      drive(i == 0, i == n - 1, base + 32'(i));
      if (expect_out)
        exp_q.push_back(eth_word_t'{sop: (i == 0), eop: (i == n - 1), data: base + 32'(i)});
    end
    idle_in();
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] b2b [6];
    b2b = '{32'h21, 32'h22, 32'h23, 32'h31, 32'h32, 32'h33};
    resetN   = 1'b0;
    inSop    = 1'b0;
    inEop    = 1'b0;
    inData   = '0;
    outStall = 1'b0;
    wait_cyc(3);
    check("rst_outData", 64'(outData), 64'd0);
    check("rst_outSop", 64'(outSop), 64'd0);
    check("rst_outEop", 64'(outEop), 64'd0);
    check("rst_bufLevel", 64'(bufLevel), 64'd0);
    check("rst_dropCount", 64'(dropCount), 64'd0);
    resetN = 1'b1;
    wait_cyc(2);

    // Basic forward with latency check
    send(4, 32'h11, 1'b1);
    @(posedge clk);
    #1;
    check("basic_lat_sop", 64'(outSop), 64'd1);
    check("basic_lat_data", 64'(outData), 64'h11);
    wait_cyc(6);
    check("basic_drop", 64'(dropCount), 64'd0);
    check("basic_level", 64'(bufLevel), 64'd0);

    // Stall hold, then back-to-back release
    @(negedge clk) outStall = 1'b1;
    send(3, 32'h21, 1'b1);
    send(3, 32'h31, 1'b1);
    wait_cyc(3);
    check("stall_level", 64'(bufLevel), 64'd6);
    check("stall_no_out", 64'({outSop, outData}), 64'd0);
    @(negedge clk) outStall = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      check("stall_b2b", 64'({outSop, outEop, outData}),
            64'({(k % 3) == 0, (k % 3) == 2, b2b[k]}));
    end
    wait_cyc(3);

    // Stall re-asserted during first packet
    @(negedge clk) outStall = 1'b1;
    send(3, 32'h41, 1'b1);
    send(3, 32'h51, 1'b1);
    wait_cyc(2);
    @(negedge clk) outStall = 1'b0;
    @(posedge clk);
    #1;
    check("restall_sop", 64'({outSop, outData}), 64'({1'b1, 32'h41}));
    @(negedge clk) outStall = 1'b1;
    wait_cyc(5);
    check("restall_level", 64'(bufLevel), 64'd3);
    check("restall_idle", 64'(outSop), 64'd0);
    @(negedge clk) outStall = 1'b0;
    wait_cyc(6);
    check("restall_drain", 64'(bufLevel), 64'd0);

    // Overflow: 20-word packet into 16-word buffer
    @(negedge clk) outStall = 1'b1;
    send(20, 32'h100, 1'b0);
    check("ovf_drop", 64'(dropCount), 64'd1);
    check("ovf_level", 64'(bufLevel), 64'd0);
    send(2, 32'h200, 1'b1);
    check("ovf_next_level", 64'(bufLevel), 64'd2);
    @(negedge clk) outStall = 1'b0;
    wait_cyc(6);
    check("ovf_drain", 64'(bufLevel), 64'd0);

    // Abort by new sop
    drive(1'b1, 1'b0, 32'h90);
    drive(1'b0, 1'b0, 32'h91);
    drive(1'b0, 1'b0, 32'h92);
    send(3, 32'hA0, 1'b1);
    wait_cyc(6);
    check("abort_drop", 64'(dropCount), 64'd2);
    check("abort_level", 64'(bufLevel), 64'd0);

    // Single-word packet
    send(1, 32'hDEADBEEF, 1'b1);
    @(posedge clk);
    #1;
    check("single", 64'({outSop, outEop, outData}), 64'({2'b11, 32'hDEADBEEF}));
    wait_cyc(3);

    // Reset while a packet is being output and another is arriving
    mon_ignore = 1'b1;
    for (int i = 0; i < 4; i++) drive(i == 0, i == 3, 32'h300 + 32'(i));
    drive(1'b1, 1'b0, 32'h400);
    drive(1'b0, 1'b0, 32'h401);
    @(negedge clk);
    check("rstmid_busy", 64'(outData), 64'h301);
    resetN = 1'b0;
    inSop  = 1'b0;
    inEop  = 1'b0;
    inData = 32'h402;
    #1;
    check("rstmid_outs", 64'({outSop, outEop, outData}), 64'd0);
    check("rstmid_level", 64'(bufLevel), 64'd0);
    check("rstmid_drop", 64'(dropCount), 64'd0);
    @(negedge clk);
    resetN = 1'b1;
    mon_ignore = 1'b0;
    for (int i = 3; i < 8; i++) drive(1'b0, i == 7, 32'h400 + 32'(i));
    idle_in();
    wait_cyc(4);
    check("rstmid_orphan_level", 64'(bufLevel), 64'd0);
    send(3, 32'h500, 1'b1);
    wait_cyc(8);
    check("rstmid_after_level", 64'(bufLevel), 64'd0);

    wait_cyc(5);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/eth_ingress_buf.md
# eth_ingress_buf

Store-and-forward ingress packet buffer that sits directly upstream of one input port of the ethernet switch (`eth_sw`). It captures the contiguous sop/data/eop word stream from the line side, which cannot be back-pressured. Only complete packets are forwarded. Packets that overflow the buffer or are truncated by a new sop are discarded. Because whole packets are stored, the switch's per-port stall can be honoured at packet boundaries without ever breaking a packet on the output.

## Interface
- `DEPTH`, 64: buffer depth in 32-bit words; power of 2, ≥4.
- `clk`  input  1  sole clock; all logic on rising edge.
- `resetN`  input  1  asynchronous, active-low reset.
- `inData`  input  32  line-side data; valid every cycle from inSop through inEop inclusive.
- `inSop`  input  1  first word of packet.
- `inEop`  input  1  last word of packet (may coincide with inSop).
- `outData`  output  32  to switch inDataX; 0 when idle.
- `outSop`  output  1  to switch inSopX.
- `outEop`  output  1  to switch inEopX.
- `outStall`  input  1  from switch portXStall; blocks start of a new packet.
- `bufLevel`  output  $clog2(DEPTH)+1  words held (committed + in-progress).
- `dropCount`  output  16  dropped-packet count, saturates at 0xFFFF.

## Operation
- Memory entry: {sop, eop, data[31:0]}.
- Pointers: `wrPtr` (tentative write), `commitPtr` (end of last complete packet), `rdPtr`; all are $clog2(DEPTH)+1 bits, with wrap by natural overflow.
- `pktCount` holds the number of committed, unread packets.
- Full when wrPtr − rdPtr == DEPTH.
- Write FSM:
  - **W_IDLE**
    - inSop: write the word and go to W_RECV.
    - inSop & inEop: write the word, commit, and stay in W_IDLE.
    - Any non-sop word: discarded silently (orphan), no count.
  - **W_RECV**
    - Every cycle writes one word.
    - inEop: commit (commitPtr ← wrPtr+1, pktCount++) and go to W_IDLE.
    - inSop: abort. wrPtr rolls back to commitPtr, dropCount++, and the sop word starts a new packet, written at commitPtr (stay in W_RECV, or commit immediately if inEop).
  - **Overflow** (word arrives while full, in any state): roll back to commitPtr, dropCount++, go to W_DROP. If the overflowing word carries inEop, go to W_IDLE instead.
  - **W_DROP**
    - Discard words until inEop, then go to W_IDLE.
    - inSop: start a new packet exactly as in W_IDLE.
- Read FSM:
  - **R_IDLE**: if pktCount>0 and !outStall, load the word at rdPtr into the output registers and go to R_SEND.
  - **R_SEND**
    - Load one word per cycle, ignoring outStall.
    - After loading the eop word (pktCount−−), start the next packet in the next cycle if pktCount>0 and !outStall (back-to-back); otherwise drive zeros and go to R_IDLE.
- Simultaneous commit and eop-read: pktCount is net unchanged.
- The read side never reads beyond commitPtr.

## Timing
- Reset values: outData=0, outSop=0, outEop=0, bufLevel=0, dropCount=0. Both FSMs are idle and all pointers are 0.
- outData/outSop/outEop are registered.
- Latency: the eop word is sampled at edge T. With outStall low and the buffer otherwise empty, outSop is asserted after edge T+1.
- Once outSop is asserted, the packet's words appear on consecutive cycles through outEop; outStall is sampled only in the cycle that decides a packet start.
- dropCount and bufLevel update on the edge of the triggering event.
- Reset asserted mid-operation clears all state and outputs immediately, and any partial packet is lost. After release, upstream words without sop are orphans.

## Structure
- Package `eth_pkg`:
  - `ETH_DW`=32.
  - `eth_word_t` struct {sop, eop, data}.
  - Write-state enum {W_IDLE, W_RECV, W_DROP}.
  - Read-state enum {R_IDLE, R_SEND}.
- Sub-module `eth_dp_ram`: simple dual-port RAM, DEPTH × eth_word_t, one write port and one read port, combinational read.
- Top level holds the FSMs, pointers and counters.

## Test plan
All scenarios use DEPTH=16.
- **Basic forward:** packet 0x11,0x12,0x13,0x14 with outStall=0 → outSop with 0x11 one edge after eop capture, four contiguous words, outEop with 0x14, dropCount=0.
- **Stall hold:** outStall=1, two 3-word packets → no output and bufLevel=6. Release → 6 contiguous output cycles, back-to-back packets. Re-assert stall during the first packet → it completes and the second waits.
- **Overflow:** outStall=1, 20-word packet → dropCount=1 and bufLevel=0 after eop. A following 2-word packet is stored and emerges after release.
- **Abort:** sop plus 2 words, then a new sop 3-word packet 0xA0..0xA2 → only the 3-word packet is output, dropCount=1.
- **Single word:** inSop=inEop=1, data 0xDEADBEEF → one output cycle with outSop=outEop=1.
- **Reset mid-packet:** resetN low while output is in progress → outputs 0 and bufLevel=0 immediately. After release, the remaining upstream words are ignored and the next sop packet passes normally.
